// File: rtl/scie_pkg.sv
// Shared constants and operation encoding for the custom-3 SCIE instruction unit.
package scie_pkg;

    localparam logic [6:0] SCIE_OPCODE = 7'h7B;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;

    typedef enum logic [2:0] {
        RELU   = 3'd0,
        MAX    = 3'd1,
        MIN    = 3'd2,
        CLAMP  = 3'd3,
        LEAKY  = 3'd4,
        SATADD = 3'd5
    } scie_op_e;

endpackage

// File: rtl/scie_alu.sv
// Combinational activation/compare datapath for SCIE instructions.
// SATADD (funct3=5) is built only when SCIE_SATADD_EN is defined; otherwise it decodes as illegal.
module scie_alu
    import scie_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        [31:0]     insn,
    input  logic signed [XLEN-1:0] rs1,
    input  logic signed [XLEN-1:0] rs2,
    output logic signed [XLEN-1:0] rd,
    output logic                   err
);

    localparam int SHW = (XLEN == 64) ? 6 : 5;

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [SHW-1:0] shamt;
    logic           unused_insn_bits;

    assign opcode           = insn[OPCODE_MSB:OPCODE_LSB];
    assign funct3           = insn[FUNCT3_MSB:FUNCT3_LSB];
    assign shamt            = rs2[SHW-1:0];
    assign unused_insn_bits = ^{insn[31:FUNCT3_MSB+1], insn[FUNCT3_LSB-1:OPCODE_MSB+1]};

`ifdef SCIE_SATADD_EN
    localparam logic signed [XLEN-1:0] SAT_MAX = {1'b0, {(XLEN-1){1'b1}}};
    localparam logic signed [XLEN-1:0] SAT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic signed [XLEN-1:0] sum;
    logic signed [XLEN-1:0] sat_rd;
    logic                   ovf;

    // Overflow only when both operands share a sign that the sum does not.
    always_comb begin
        sum    = rs1 + rs2;
        ovf    = (rs1[XLEN-1] == rs2[XLEN-1]) && (sum[XLEN-1] != rs1[XLEN-1]);
        sat_rd = ovf ? (rs1[XLEN-1] ? SAT_MIN : SAT_MAX) : sum;
    end
`endif

    always_comb begin
        rd  = '0;
        err = 1'b0;
        if (opcode != SCIE_OPCODE) begin
            err = 1'b1;
        end else begin
            case (funct3)
                RELU:   rd = rs1[XLEN-1] ? '0 : rs1;
                MAX:    rd = (rs1 > rs2) ? rs1 : rs2;
                MIN:    rd = (rs1 < rs2) ? rs1 : rs2;
                CLAMP:  rd = rs1[XLEN-1] ? '0 : ((rs1 > rs2) ? rs2 : rs1);
                LEAKY:  rd = rs1[XLEN-1] ? (rs1 >>> shamt) : rs1;
`ifdef SCIE_SATADD_EN
                SATADD: rd = sat_rd;
`endif
                default: begin
                    rd  = '0;
                    err = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/scie_pipelined.sv
// Pipelined SCIE unit: valid/ready handshake around scie_alu with LATENCY stall-able stages.
// Optional SATADD operation is enabled by defining SCIE_SATADD_EN.
module scie_pipelined
    import scie_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic        [31:0]     in_insn,
    input  logic signed [XLEN-1:0] in_rs1,
    input  logic signed [XLEN-1:0] in_rs2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [XLEN-1:0] out_rd,
    output logic                   out_err
);

    logic                   advance;
    logic signed [XLEN-1:0] alu_rd;
    logic                   alu_err;

    logic [LATENCY-1:0]     valid_q, valid_d;
    logic [LATENCY-1:0]     err_q,   err_d;
    logic signed [XLEN-1:0] rd_q [LATENCY];
    logic signed [XLEN-1:0] rd_d [LATENCY];

    scie_alu #(.XLEN(XLEN)) u_alu (
        .insn (in_insn),
        .rs1  (in_rs1),
        .rs2  (in_rs2),
        .rd   (alu_rd),
        .err  (alu_err)
    );

    // One global enable: the whole pipe moves only when the last stage can empty.
    assign advance  = !valid_q[LATENCY-1] || out_ready;
    assign in_ready = advance;

    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        for (int i = 0; i < LATENCY; i++) begin
            rd_d[i] = rd_q[i];
        end
        if (advance) begin
            valid_d[0] = in_valid;
            rd_d[0]    = in_valid ? alu_rd : '0;
            err_d[0]   = in_valid & alu_err;
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                rd_d[i]    = rd_q[i-1];
                err_d[i]   = err_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int i = 0; i < LATENCY; i++) begin
                rd_q[i] <= rd_d[i];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_rd    = rd_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];

endmodule

// File: tb/tb_scie_pipelined.sv
// Scoreboard bench for scie_pipelined: directed requests push expectations, a monitor pops on each retire.
module tb_scie_pipelined;
    import scie_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = 2;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   in_valid;
    logic                   in_ready;
    logic        [31:0]     in_insn;
    logic signed [XLEN-1:0] in_rs1;
    logic signed [XLEN-1:0] in_rs2;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [XLEN-1:0] out_rd;
    logic                   out_err;

    typedef struct packed {
        logic signed [XLEN-1:0] rd;
        logic                   err;
    } exp_t;

    exp_t sb[$];
    int   total       = 0;
    int   bad         = 0;
    int   cyc         = 0;
    int   stall_lo    = 1000000;
    int   stall_hi    = 0;
    logic force_stall = 1'b0;

    always #5 clock = ~clock;

    scie_pipelined #(.XLEN(XLEN), .LATENCY(LAT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_insn   (in_insn),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_err   (out_err)
    );

    always @(posedge clock) cyc++;

    always @(posedge clock) begin
        #1;
        out_ready = !(force_stall || (cyc >= stall_lo && cyc <= stall_hi));
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        logic [31:0] w;
        w        = '0;
        w[6:0]   = op;
        w[14:12] = f3;
        return w;
    endfunction

    task automatic applyStimulus(input logic [31:0] insn, input logic signed [XLEN-1:0] a,
                                 input logic signed [XLEN-1:0] b,
                                 input logic signed [XLEN-1:0] exp_rd, input logic exp_err);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_insn  = insn;
        in_rs1   = a;
        in_rs2   = b;
        while (!in_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
        end else begin
            e.rd  = exp_rd;
            e.err = exp_err;
            sb.push_back(e);
            @(posedge clock);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clock);
            g++;
        end
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset_n && out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", {63'd0, out_valid}, 64'd0);
            end else if (out_ready) begin
                e = sb.pop_front();
                checkOutput("result_rd", 64'(out_rd), 64'(e.rd));
                checkOutput("result_err", {63'd0, out_err}, {63'd0, e.err});
            end else begin
                checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
                checkOutput("stall_hold_rd", 64'(out_rd), 64'(sb[0].rd));
                checkOutput("stall_hold_err", {63'd0, out_err}, {63'd0, sb[0].err});
            end
        end
    end

    initial begin
        logic signed [XLEN-1:0] relu_in [5];
        logic signed [XLEN-1:0] relu_ex [5];
        logic signed [XLEN-1:0] bp_in   [8];
        logic signed [XLEN-1:0] bp_ex   [8];
        int base;

        relu_in = '{-11, 7, 39, -1, 0};
        relu_ex = '{0, 7, 39, 0, 0};
        bp_in   = '{-10, -7, -4, -1, 2, 5, 8, 11};
        bp_ex   = '{0, 0, 0, 0, 2, 5, 8, 11};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_insn   = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        out_ready = 1'b1;

        #12;
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_out_rd", 64'(out_rd), 64'd0);
        checkOutput("reset_out_err", {63'd0, out_err}, 64'd0);
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clock);
        reset_n = 1'b1;

        applyStimulus(mk(SCIE_OPCODE, RELU), 5, 0, 5, 1'b0);
        checkOutput("lat_not_early", {63'd0, out_valid}, 64'd0);
        repeat (LAT - 1) @(posedge clock);
        #1;
        checkOutput("lat_on_time", {63'd0, out_valid}, 64'd1);
        drain();

        for (int i = 0; i < 5; i++)
            applyStimulus(mk(SCIE_OPCODE, RELU), relu_in[i], 0, relu_ex[i], 1'b0);
        drain();

        applyStimulus(mk(SCIE_OPCODE, MAX),   -5,  3,  3, 1'b0);
        applyStimulus(mk(SCIE_OPCODE, MIN),   -5,  3, -5, 1'b0);
        applyStimulus(mk(SCIE_OPCODE, CLAMP), 50, 40, 40, 1'b0);
        applyStimulus(mk(SCIE_OPCODE, CLAMP), -26, 40, 0, 1'b0);
        applyStimulus(mk(SCIE_OPCODE, CLAMP), 10, -4, -4, 1'b0);
        applyStimulus(mk(SCIE_OPCODE, LEAKY), -64, 3, -8, 1'b0);
        applyStimulus(mk(SCIE_OPCODE, LEAKY), -1,  4, -1, 1'b0);
        applyStimulus(mk(SCIE_OPCODE, LEAKY), 41,  2, 41, 1'b0);
        drain();

        applyStimulus(mk(7'h33, 3'd0), 5, 1, 0, 1'b1);
        applyStimulus(mk(SCIE_OPCODE, 3'd6), 5, 1, 0, 1'b1);
        applyStimulus(mk(SCIE_OPCODE, 3'd7), -9, 1, 0, 1'b1);
`ifdef SCIE_SATADD_EN
        applyStimulus(mk(SCIE_OPCODE, SATADD), 32'sh7FFF_FFF0, 32'sh20, 32'sh7FFF_FFFF, 1'b0);
        applyStimulus(mk(SCIE_OPCODE, SATADD), 32'sh8000_0010, -32'sh20, 32'sh8000_0000, 1'b0);
        applyStimulus(mk(SCIE_OPCODE, SATADD), 100, -30, 70, 1'b0);
`else
        applyStimulus(mk(SCIE_OPCODE, SATADD), 32'sh7FFF_FFF0, 32'sh20, 0, 1'b1);
`endif
        drain();

        base     = cyc;
        stall_lo = base + 3;
        stall_hi = base + 7;
        for (int i = 0; i < 8; i++)
            applyStimulus(mk(SCIE_OPCODE, RELU), bp_in[i], 0, bp_ex[i], 1'b0);
        drain();
        stall_lo = 1000000;
        stall_hi = 0;

        force_stall = 1'b1;
        @(posedge clock);
        #2;
        applyStimulus(mk(SCIE_OPCODE, MAX), 1, 2, 2, 1'b0);
        applyStimulus(mk(SCIE_OPCODE, MAX), 3, 4, 4, 1'b0);
        checkOutput("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("async_reset_rd", 64'(out_rd), 64'd0);
        sb.delete();
        @(negedge clock);
        reset_n     = 1'b1;
        force_stall = 1'b0;
        repeat (6) begin
            @(posedge clock);
            #2;
            checkOutput("no_stale_result", {63'd0, out_valid}, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scie_pipelined.md
Name: scie_pipelined

Overview:
- Pipelined, multi-mode successor to the single-cycle custom-instruction unit.
- Decodes a RISC-V custom-3 instruction (opcode 7'h7B) and selects an activation/compare operation by funct3.
- Computes over XLEN-bit signed operands and delivers the result after a configurable number of register stages.
- Sits beside the core pipeline behind a valid/ready handshake, so it can be back-pressured by writeback.

Parameters:
- XLEN, 32, operand and result width in bits (legal: 32 or 64).
- LATENCY, 2, number of register stages from input accept to output valid (>=1).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_insn  in  32  instruction word; [6:0] opcode, [14:12] funct3.
- in_rs1  in  XLEN  signed source 1.
- in_rs2  in  XLEN  signed source 2.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_rd  out  XLEN  signed result.
- out_err  out  1  illegal opcode/funct3 flag, qualified by out_valid.

Behaviour:
- Reset (async assert, sync deassert handled upstream): all stage valid bits 0; out_valid=0, out_rd=0, out_err=0.
- Accept: a request is taken when in_valid && in_ready.
- Op decode (combinational, stage 0 input), funct3:
  - 0 RELU: rd = rs1<0 ? 0 : rs1.
  - 1 MAX: signed max(rs1, rs2).
  - 2 MIN: signed min(rs1, rs2).
  - 3 CLAMP: rd = rs1<0 ? 0 : (rs1>rs2 ? rs2 : rs1). rs2 is treated as the upper bound; if rs2<0 the result is rs2.
  - 4 LEAKY: rd = rs1<0 ? (rs1 >>> rs2[4:0]) : rs1. Arithmetic shift; for XLEN=64 the shift amount uses rs2[5:0].
  - 5-7 and opcode != 7'h7B: rd=0, err=1.
- Pipeline: LATENCY stages, each holding {valid, rd, err}.
  - Global stall: advance = !out_valid || out_ready. When advance=0 every stage holds its contents.
  - in_ready = advance (combinational from out_valid/out_ready). No combinational path from in_valid to in_ready.
  - Bubbles do not collapse; throughput is 1 per cycle when out_ready=1.
- Latency: a request accepted at edge N appears with out_valid=1 after edge N+LATENCY-1, i.e. visible in the cycle following LATENCY accepting edges, provided there is no stall.
- Ordering: strict in-order; no result is dropped or duplicated under any out_ready pattern.
- Output stability: out_rd/out_err must not change while out_valid && !out_ready.
- Simultaneous events: a full pipe with out_ready=1 and in_valid=1 retires one result and accepts one request in the same cycle.
- Reset mid-operation: all in-flight results are discarded; out_valid drops asynchronously.
- Arithmetic: all compares are signed XLEN. No width growth; results are exactly XLEN bits.

Optional Feature:
- Macro: SCIE_SATADD_EN.
- Defined: funct3=5 is SATADD, rd = rs1+rs2 saturated to the signed XLEN range (0x7FFF_FFFF / 0x8000_0000 for XLEN=32), err=0.
- Undefined: funct3=5 is illegal (rd=0, err=1). No adder logic is instantiated.

Decomposition:
- Package scie_pkg holds:
  - SCIE_OPCODE = 7'h7B.
  - enum scie_op_e {RELU, MAX, MIN, CLAMP, LEAKY, SATADD}.
  - The funct3 field position constants.
- Sub-module scie_alu: purely combinational, parameterised by XLEN.
  - Inputs: insn, rs1, rs2.
  - Outputs: rd, err.
- scie_pipelined owns the handshake and the stage registers.

Test Plan:
- RELU, XLEN=32, LATENCY=2, out_ready=1: rs1 = -11, 7, 39, -1, 0 streamed back-to-back -> out_rd = 0, 7, 39, 0, 0 on consecutive cycles, first result two edges after the first accept.
- MAX/MIN/CLAMP: (rs1,rs2) = (-5,3) -> MAX 3, MIN -5; CLAMP (50,40) -> 40; CLAMP (-26,40) -> 0; CLAMP (10,-4) -> -4.
- LEAKY: rs1=-64, rs2=3 -> -8; rs1=-1, rs2=4 -> -1; rs1=41, rs2=2 -> 41.
- Back-pressure: stream 8 requests with out_ready=0 for cycles 3-7.
  - in_ready=0 while out_valid && !out_ready.
  - All 8 results arrive in order and unchanged while stalled.
- Illegal: opcode 7'h33 with funct3=0, or opcode 7'h7B with funct3=6 -> out_rd=0, out_err=1.
  - With SCIE_SATADD_EN: 0x7FFF_FFF0 + 0x20 -> 0x7FFF_FFFF, err=0. Without it: err=1.
- Reset: assert reset_n=0 with 2 results in flight -> out_valid=0 immediately; after release, no stale results emerge.
